// File: rtl/image_proc_pkg.sv
// Shared definitions for the pixel tap sampler.
//   CNT_W             : width of the column/row position counters
//   CNT_MAX           : largest frame dimension the counters can represent
//   THRESHOLD_DEFAULT : default luminance at or above which a tap reads as lit
//   sampler_state_e   : sampler FSM state encoding
package image_proc_pkg;

    localparam int unsigned CNT_W             = 11;
    localparam int unsigned CNT_MAX           = 2047;
    localparam int unsigned THRESHOLD_DEFAULT = 192;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitFrame = 2'd1,
        StActive    = 2'd2
    } sampler_state_e;

endpackage

// File: rtl/tap_capture.sv
// One tap of the sampler: compares the current pixel position against the tap
// coordinate, thresholds the luminance and holds the working lit/hit bits for the
// frame in progress.
// Ports:
//   clock, reset  : pixel clock, synchronous active-high reset
//   i_pix_en      : current pixel is accepted into the frame
//   i_new_frame   : start a fresh frame (also held high while not sampling)
//   i_x, i_y      : position of the current pixel
//   i_data        : luminance of the current pixel
//   o_lit, o_hit  : working lit bit and "tap reached" bit for this frame
module tap_capture
    import image_proc_pkg::*;
#(
    parameter int unsigned TAP_X     = 0,
    parameter int unsigned TAP_Y     = 0,
    parameter int unsigned THRESHOLD = THRESHOLD_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_pix_en,
    input  logic             i_new_frame,
    input  logic [CNT_W-1:0] i_x,
    input  logic [CNT_W-1:0] i_y,
    input  logic [7:0]       i_data,
    output logic             o_lit,
    output logic             o_hit
);

    localparam logic [CNT_W-1:0] LP_X = CNT_W'(TAP_X);
    localparam logic [CNT_W-1:0] LP_Y = CNT_W'(TAP_Y);

    logic w_match;
    logic w_bright;
    logic r_lit;
    logic r_hit;

    assign w_match  = i_pix_en && (i_x == LP_X) && (i_y == LP_Y);
    assign w_bright = (32'(i_data) >= THRESHOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lit <= 1'b0;
            r_hit <= 1'b0;
        end else if (i_new_frame) begin
            // A tap at (0,0) lands in the frame that is just starting.
            r_lit <= w_match && w_bright;
            r_hit <= w_match;
        end else if (w_match) begin
            r_lit <= w_bright;
            r_hit <= 1'b1;
        end
    end

    assign o_lit = r_lit;
    assign o_hit = r_hit;

endmodule

// File: rtl/pixel_tap_sampler.sv
// Samples three fixed pixel positions of a video stream against a luminance
// threshold and publishes the per-tap result once per completed frame.
// Ports:
//   clock, reset   : pixel clock, synchronous active-high reset
//   enable         : 1 = sampling armed, 0 = idle (drops the frame in progress)
//   pixel_valid    : data carries an active pixel
//   frame_start    : current valid pixel is (0,0)
//   data           : pixel luminance
//   sample_data    : lit bits of the last completed frame (bit n = tap n)
//   sample_valid   : one-cycle strobe when sample_data/tap_missed update
//   tap_missed     : bit n = tap n was never reached in the last completed frame
//   frame_count    : number of published frames (wraps)
// FRAME_WIDTH and FRAME_HEIGHT must not exceed CNT_MAX.
module pixel_tap_sampler
    import image_proc_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = 1024,
    parameter int unsigned FRAME_HEIGHT = 768,
    parameter int unsigned TAP0_X       = 63,
    parameter int unsigned TAP0_Y       = 100,
    parameter int unsigned TAP1_X       = 511,
    parameter int unsigned TAP1_Y       = 384,
    parameter int unsigned TAP2_X       = 1023,
    parameter int unsigned TAP2_Y       = 700,
    parameter int unsigned THRESHOLD    = THRESHOLD_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        pixel_valid,
    input  logic        frame_start,
    input  logic [7:0]  data,
    output logic [2:0]  sample_data,
    output logic        sample_valid,
    output logic [2:0]  tap_missed,
    output logic [15:0] frame_count
);

    localparam logic [CNT_W-1:0] LP_LAST_COL = CNT_W'(FRAME_WIDTH - 1);
    localparam logic [CNT_W-1:0] LP_HEIGHT   = CNT_W'(FRAME_HEIGHT);

    sampler_state_e   r_state;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [2:0]       r_sample_data;
    logic             r_sample_valid;
    logic [2:0]       r_tap_missed;
    logic [15:0]      r_frame_count;

    logic             w_fs_pix;
    logic             w_in_frame;
    logic             w_starting;
    logic             w_take;
    logic             w_new_frame;
    logic             w_publish;
    logic [CNT_W-1:0] w_x;
    logic [CNT_W-1:0] w_y;
    logic [2:0]       w_lit;
    logic [2:0]       w_hit;

    assign w_fs_pix   = pixel_valid && frame_start;
    assign w_in_frame = enable && (r_state == StActive);
    assign w_starting = enable && (r_state == StWaitFrame) && w_fs_pix;

    // frame_start overrides whatever the counters hold.
    assign w_x = frame_start ? '0 : r_col;
    assign w_y = frame_start ? '0 : r_row;

    // Row FRAME_HEIGHT is the saturated "past end of frame" row: nothing is taken there.
    assign w_take      = pixel_valid && (w_in_frame || w_starting) && (w_y != LP_HEIGHT);
    assign w_new_frame = !w_in_frame || w_fs_pix;
    assign w_publish   = w_in_frame && w_fs_pix;

    tap_capture #(
        .TAP_X     (TAP0_X),
        .TAP_Y     (TAP0_Y),
        .THRESHOLD (THRESHOLD)
    ) u_tap0 (
        .clock       (clock),
        .reset       (reset),
        .i_pix_en    (w_take),
        .i_new_frame (w_new_frame),
        .i_x         (w_x),
        .i_y         (w_y),
        .i_data      (data),
        .o_lit       (w_lit[0]),
        .o_hit       (w_hit[0])
    );

    tap_capture #(
        .TAP_X     (TAP1_X),
        .TAP_Y     (TAP1_Y),
        .THRESHOLD (THRESHOLD)
    ) u_tap1 (
        .clock       (clock),
        .reset       (reset),
        .i_pix_en    (w_take),
        .i_new_frame (w_new_frame),
        .i_x         (w_x),
        .i_y         (w_y),
        .i_data      (data),
        .o_lit       (w_lit[1]),
        .o_hit       (w_hit[1])
    );

    tap_capture #(
        .TAP_X     (TAP2_X),
        .TAP_Y     (TAP2_Y),
        .THRESHOLD (THRESHOLD)
    ) u_tap2 (
        .clock       (clock),
        .reset       (reset),
        .i_pix_en    (w_take),
        .i_new_frame (w_new_frame),
        .i_x         (w_x),
        .i_y         (w_y),
        .i_data      (data),
        .o_lit       (w_lit[2]),
        .o_hit       (w_hit[2])
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= StIdle;
            r_col          <= '0;
            r_row          <= '0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_tap_missed   <= '0;
            r_frame_count  <= '0;
        end else begin
            // The working bits still describe the finished frame on this edge.
            r_sample_valid <= w_publish;
            if (w_publish) begin
                r_sample_data <= w_lit;
                r_tap_missed  <= ~w_hit;
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (!enable) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle:      r_state <= StWaitFrame;
                    StWaitFrame: if (w_fs_pix) r_state <= StActive;
                    StActive:    r_state <= StActive;
                    default:     r_state <= StIdle;
                endcase
            end

            if (w_take) begin
                if (w_x == LP_LAST_COL) begin
                    r_col <= '0;
                    r_row <= w_y + CNT_W'(1);
                end else begin
                    r_col <= w_x + CNT_W'(1);
                    r_row <= w_y;
                end
            end else if (!w_in_frame) begin
                r_col <= '0;
                r_row <= '0;
            end
        end
    end

    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign tap_missed   = r_tap_missed;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_pixel_tap_sampler.sv
// Directed bench for pixel_tap_sampler on a scaled-down 8x6 frame. A second
// instance with every tap at (0,0) covers the frame_start coincidence case.
module tb_pixel_tap_sampler;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = 6;
    localparam int unsigned T0X  = 1;
    localparam int unsigned T0Y  = 1;
    localparam int unsigned T1X  = 4;
    localparam int unsigned T1Y  = 2;
    localparam int unsigned T2X  = 7;
    localparam int unsigned T2Y  = 4;
    localparam logic [7:0]  FILL = 8'd191;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        pixel_valid;
    logic        frame_start;
    logic [7:0]  data;

    logic [2:0]  m_sample_data;
    logic        m_sample_valid;
    logic [2:0]  m_tap_missed;
    logic [15:0] m_frame_count;
    logic [2:0]  z_sample_data;
    logic        z_sample_valid;
    logic [2:0]  z_tap_missed;
    logic [15:0] z_frame_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pixel_tap_sampler #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .TAP0_X       (T0X),
        .TAP0_Y       (T0Y),
        .TAP1_X       (T1X),
        .TAP1_Y       (T1Y),
        .TAP2_X       (T2X),
        .TAP2_Y       (T2Y),
        .THRESHOLD    (192)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .data         (data),
        .sample_data  (m_sample_data),
        .sample_valid (m_sample_valid),
        .tap_missed   (m_tap_missed),
        .frame_count  (m_frame_count)
    );

    pixel_tap_sampler #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .TAP0_X       (0),
        .TAP0_Y       (0),
        .TAP1_X       (0),
        .TAP1_Y       (0),
        .TAP2_X       (0),
        .TAP2_Y       (0),
        .THRESHOLD    (192)
    ) dut_z (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .data         (data),
        .sample_data  (z_sample_data),
        .sample_valid (z_sample_valid),
        .tap_missed   (z_tap_missed),
        .frame_count  (z_frame_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pix(input logic fs, input logic [7:0] d);
        pixel_valid = 1'b1;
        frame_start = fs;
        data        = d;
        tick();
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        data        = 8'h00;
    endtask

    task automatic fs_pix(input logic [7:0] d);
        pix(1'b1, d);
    endtask

    function automatic logic [7:0] tap_val(input int x, input int y,
                                           input logic [7:0] d0, input logic [7:0] d1,
                                           input logic [7:0] d2);
        if (x == int'(T0X) && y == int'(T0Y)) return d0;
        if (x == int'(T1X) && y == int'(T1Y)) return d1;
        if (x == int'(T2X) && y == int'(T2Y)) return d2;
        return FILL;
    endfunction

    // Pixels (1,0) onward for the given number of rows, one blank cycle per line.
    task automatic body(input int rows, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2);
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < int'(W); x++) begin
                if (x == 0 && y == 0) continue;
                pix(1'b0, tap_val(x, y, d0, d1, d2));
            end
            tick();
        end
    endtask

    initial begin
        // Reset wins over enable and a frame_start pixel.
        reset       = 1'b1;
        enable      = 1'b1;
        pixel_valid = 1'b1;
        frame_start = 1'b1;
        data        = 8'hFF;
        tick();
        tick();
        chk("rst_data",   16'(m_sample_data),  16'h0);
        chk("rst_valid",  16'(m_sample_valid), 16'h0);
        chk("rst_missed", 16'(m_tap_missed),   16'h0);
        chk("rst_count",  m_frame_count,       16'h0);

        reset       = 1'b0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        data        = 8'h00;
        tick();
        pix(1'b0, 8'hFF);
        pix(1'b0, 8'hFF);
        fs_pix(8'h00);
        chk("enter_no_pub_valid", 16'(m_sample_valid), 16'h0);
        chk("enter_no_pub_count", m_frame_count,       16'h0);

        // Full frame, then pixels past the last row that must not wrap onto tap0.
        body(H, 8'd200, 8'd100, 8'd255);
        for (int i = 0; i < int'(W) + 2; i++) pix(1'b0, 8'h00);
        fs_pix(8'h00);
        chk("f1_valid",  16'(m_sample_valid), 16'h1);
        chk("f1_data",   16'(m_sample_data),  16'h5);
        chk("f1_missed", 16'(m_tap_missed),   16'h0);
        chk("f1_count",  m_frame_count,       16'h1);
        tick();
        chk("strobe_low",  16'(m_sample_valid), 16'h0);
        chk("data_held",   16'(m_sample_data),  16'h5);

        // Truncated frame: tap2 row never reached.
        body(3, 8'd200, 8'd100, 8'd255);
        fs_pix(8'h00);
        chk("trunc_data",   16'(m_sample_data), 16'h1);
        chk("trunc_missed", 16'(m_tap_missed),  16'h4);
        chk("trunc_count",  m_frame_count,      16'h2);

        // Abort mid-frame with enable low: no publish, outputs held.
        body(3, 8'd255, 8'd255, 8'd255);
        enable = 1'b0;
        tick();
        chk("abort_valid",  16'(m_sample_valid), 16'h0);
        chk("abort_count",  m_frame_count,       16'h2);
        chk("abort_data",   16'(m_sample_data),  16'h1);
        chk("abort_missed", 16'(m_tap_missed),   16'h4);
        enable = 1'b1;
        tick();
        pix(1'b0, 8'hFF);
        fs_pix(8'h00);
        chk("reenter_valid", 16'(m_sample_valid), 16'h0);
        chk("reenter_count", m_frame_count,       16'h2);

        // Threshold boundary: 192 lit, 191 not, 100 not.
        body(H, 8'd192, 8'd191, 8'd100);
        fs_pix(8'd100);
        chk("thr_valid",  16'(m_sample_valid), 16'h1);
        chk("thr_data",   16'(m_sample_data),  16'h1);
        chk("thr_missed", 16'(m_tap_missed),   16'h0);
        chk("thr_count",  m_frame_count,       16'h3);
        chk("z0_data",    16'(z_sample_data),  16'h0);
        chk("z0_missed",  16'(z_tap_missed),   16'h0);

        // (0,0) taps: the coincident frame_start pixel belongs to the new frame.
        fs_pix(8'd255);
        chk("z_coincident_data", 16'(z_sample_data),  16'h0);
        chk("z_coincident_vld",  16'(z_sample_valid), 16'h1);
        chk("m_onepix_missed",   16'(m_tap_missed),   16'h7);
        fs_pix(8'd255);
        chk("z_prev_data",   16'(z_sample_data), 16'h7);
        chk("z_prev_missed", 16'(z_tap_missed),  16'h0);
        chk("z_count",       z_frame_count,      16'h5);

        // Preload the counter to 65535 with one-pixel frames, then wrap.
        for (int i = 0; i < 65530; i++) fs_pix(8'h00);
        chk("preload_count", m_frame_count, 16'hFFFF);
        body(H, 8'd255, 8'd0, 8'd255);
        fs_pix(8'h00);
        chk("wrap_count",  m_frame_count,       16'h0);
        chk("wrap_valid",  16'(m_sample_valid), 16'h1);
        chk("wrap_data",   16'(m_sample_data),  16'h5);
        chk("wrap_missed", 16'(m_tap_missed),   16'h0);

        // Reset mid-frame, asserted together with a frame_start pixel.
        body(2, 8'd255, 8'd255, 8'd255);
        reset       = 1'b1;
        pixel_valid = 1'b1;
        frame_start = 1'b1;
        data        = 8'hFF;
        tick();
        chk("midrst_data",   16'(m_sample_data),  16'h0);
        chk("midrst_valid",  16'(m_sample_valid), 16'h0);
        chk("midrst_missed", 16'(m_tap_missed),   16'h0);
        chk("midrst_count",  m_frame_count,       16'h0);
        chk("midrst_zdata",  16'(z_sample_data),  16'h0);
        reset       = 1'b0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        data        = 8'h00;
        tick();
        fs_pix(8'h00);
        chk("post_rst_valid", 16'(m_sample_valid), 16'h0);
        chk("post_rst_count", m_frame_count,       16'h0);
        body(H, 8'd200, 8'd200, 8'd200);
        fs_pix(8'h00);
        chk("post_rst_data",   16'(m_sample_data), 16'h7);
        chk("post_rst_missed", 16'(m_tap_missed),  16'h0);
        chk("post_rst_f_cnt",  m_frame_count,      16'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
